// File: rtl/rounder_sat_pipe_if.sv
// rounder_sat_pipe_if: valid/ready stream bundle for rounder_sat_pipe
//
// Parameters
//   CH     channels packed per beat, channel 0 in the LSBs
//   IN_W   input sample width (two's complement)
//   OUT_W  output sample width (signed)
//
// Signals
//   s_valid  upstream beat valid
//   s_ready  beat accepted when s_valid & s_ready
//   s_mode   rounding mode, travels with the beat
//   s_data   packed input samples
//   m_valid  output beat valid
//   m_ready  downstream ready
//   m_data   packed rounded/saturated samples
//   m_sat    per-channel saturation flag, aligned with m_data
//
// Modports
//   master  the side that produces input beats and consumes output beats
//   slave   the rounder itself
interface rounder_sat_pipe_if #(
    parameter int CH    = 2,
    parameter int IN_W  = 24,
    parameter int OUT_W = 16
);
    logic                s_valid;
    logic                s_ready;
    logic [1:0]          s_mode;
    logic [CH*IN_W-1:0]  s_data;
    logic                m_valid;
    logic                m_ready;
    logic [CH*OUT_W-1:0] m_data;
    logic [CH-1:0]       m_sat;

    modport master (
        output s_valid, s_mode, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_sat
    );

    modport slave (
        input  s_valid, s_mode, s_data, m_ready,
        output s_ready, m_valid, m_data, m_sat
    );
endinterface

// File: rtl/rounder_sat_pipe.sv
// rounder_sat_pipe: 3-stage multi-channel fixed-point rounder/saturator with valid/ready flow
//
// Drops FRAC_W fraction bits from each IN_W two's-complement sample using a
// per-beat rounding mode, then saturates to signed OUT_W.
//   mode 0 TRUNC      floor toward -inf
//   mode 1 HALF_AWAY  ties away from zero
//   mode 2 HALF_EVEN  ties to even
//   mode 3 HALF_UP    ties toward +inf
//
// Ports
//   clk          clock, rising edge
//   reset_b      asynchronous active-low reset
//   io           rounder_sat_pipe_if.slave stream bundle (s_* in, m_* out)
//   sat_cnt_clr  synchronous clear of sat_cnt
//   sat_cnt      count of output handshakes carrying any saturated channel
//
// Optional feature
//   ROUNDER_SAT_CNT_EN  when defined, sat_cnt is a 16-bit sticky counter;
//                       otherwise sat_cnt is tied to 0 and has no flops.
//
// Stages
//   S1 registers data and mode, S2 rounds into IN_W-FRAC_W+1 bits, S3
//   saturates and drives m_data/m_sat. All stages advance together on
//   en = m_ready | ~m_valid, so bubbles are carried, not squeezed.
module rounder_sat_pipe #(
    parameter int CH     = 2,
    parameter int IN_W   = 24,
    parameter int FRAC_W = 7,
    parameter int OUT_W  = 16
) (
    input  logic                clk,
    input  logic                reset_b,
    rounder_sat_pipe_if.slave   io,
    input  logic                sat_cnt_clr,
    output logic [15:0]         sat_cnt
);
    // One extra bit over the integer part so that q+1 can never wrap.
    localparam int RW = IN_W - FRAC_W + 1;

    logic                en;
    logic                v1_q, v2_q, v3_q;
    logic [CH*IN_W-1:0]  d1_q;
    logic [1:0]          mode1_q;
    logic [CH*RW-1:0]    r2_q, r2_d;
    logic [CH*OUT_W-1:0] data3_q, data3_d;
    logic [CH-1:0]       sat3_q, sat3_d;

    function automatic logic [RW-1:0] rnd(input logic [IN_W-1:0] x, input logic [1:0] mode);
        logic [RW-1:0]     q;
        logic [FRAC_W-1:0] f;
        logic [FRAC_W-1:0] h;
        logic              gt, eq, inc;
        q   = RW'($signed(x) >>> FRAC_W);
        f   = x[FRAC_W-1:0];
        h   = FRAC_W'(1) << (FRAC_W - 1);
        gt  = f > h;
        eq  = f == h;
        inc = mode == 2'd0 ? 1'b0 :
              mode == 2'd1 ? gt | (eq & ~x[IN_W-1]) :
              mode == 2'd2 ? gt | (eq & q[0]) :
                             gt | eq;
        return q + RW'(inc);
    endfunction

    // Returns {sat_flag, value}. The value fits when every bit from the
    // output sign bit upward matches.
    function automatic logic [OUT_W:0] sat(input logic [RW-1:0] r);
        logic [RW-OUT_W:0] top;
        logic              ovf;
        top = r[RW-1:OUT_W-1];
        ovf = !((&top) | ~(|top));
        return ovf ? {1'b1, r[RW-1], {(OUT_W-1){~r[RW-1]}}} : {1'b0, r[OUT_W-1:0]};
    endfunction

    always_comb begin
        r2_d    = '0;
        data3_d = '0;
        sat3_d  = '0;
        for (int c = 0; c < CH; c++) begin
            r2_d[c*RW +: RW]                    = rnd(d1_q[c*IN_W +: IN_W], mode1_q);
            {sat3_d[c], data3_d[c*OUT_W +: OUT_W]} = sat(r2_q[c*RW +: RW]);
        end
    end

    assign en         = io.m_ready | ~v3_q;
    assign io.s_ready = en;
    assign io.m_valid = v3_q;
    assign io.m_data  = data3_q;
    assign io.m_sat   = sat3_q;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            d1_q    <= '0;
            mode1_q <= '0;
            r2_q    <= '0;
            data3_q <= '0;
            sat3_q  <= '0;
        end else if (en) begin
            v1_q <= io.s_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (io.s_valid) begin
                d1_q    <= io.s_data;
                mode1_q <= io.s_mode;
            end
            if (v1_q) r2_q <= r2_d;
            if (v2_q) begin
                data3_q <= data3_d;
                sat3_q  <= sat3_d;
            end
        end
    end

`ifdef ROUNDER_SAT_CNT_EN
    logic [15:0] sat_cnt_q, sat_cnt_d;

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_comb
        sat_cnt_d = sat_cnt_clr ? 16'd0 :
                    (v3_q & io.m_ready & (|sat3_q) & ~(&sat_cnt_q)) ? sat_cnt_q + 16'd1 :
                    sat_cnt_q;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) sat_cnt_q <= '0;
        else          sat_cnt_q <= sat_cnt_d;
    end

    assign sat_cnt = sat_cnt_q;
`else
    logic unused_sat_cnt_clr;

    assign unused_sat_cnt_clr = sat_cnt_clr;
    assign sat_cnt            = '0;
`endif
endmodule
